figo_route_sequencer: RTL and testbench
=======================================

Name: figo_route_sequencer

Overview:
- Command-driven controller that steers the Figo rover room FSM to a requested room by generating its 1-bit travel_input each clock.
- Accepts destination commands through a valid/ready FIFO and walks the rover along its fixed 8-room Hamiltonian cycle: 0→1→2→3→4→6→5→7→0.
- Checks every rover step against the expected room and parks the rover in a self-looping room (0, 2, 4, 7) when idle.
- Sits between the ISRO command interface and the rover FSM; rover room feedback is wired to room_fb.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- LVL_W, 3, width of fifo_level (holds 0..FIFO_DEPTH).
- MAX_STEPS, 8, step-count backstop per command.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- cmd_valid  in  1  destination command valid.
- cmd_room  in  3  destination room 0..7.
- cmd_ready  out  1  FIFO can accept; push occurs when cmd_valid & cmd_ready.
- room_fb  in  3  rover current room, updated after each clk edge.
- travel_out  out  1  drives rover travel_input; combinational (Mealy).
- busy  out  1  state ≠ IDLE.
- arrived  out  1  one-cycle registered pulse when target reached.
- fault  out  1  sticky fault flag.
- target_room  out  3  destination currently being served.
- fifo_level  out  LVL_W  queued command count.

Behaviour:
- Reset (reset=0 at edge):
  - State → IDLE; FIFO emptied.
  - busy=0, arrived=0, fault=0, target_room=0, fifo_level=0, step count=0.
  - travel_out=0 during reset.
- Ring successor and move bit:
  - succ: 0→1, 1→2, 2→3, 3→4, 4→6, 6→5, 5→7, 7→0.
  - Move bit is 1 for all rooms except room 6, where it is 0.
  - Park rooms (hold with bit 0): 0, 2, 4, 7.
- FIFO:
  - cmd_ready = !full & !fault.
  - Push and pop in the same cycle are allowed; level stays unchanged.
  - Pop happens only in IDLE when not empty.
  - cmd_room is captured unmodified, no filtering.
- States:
  - IDLE:
    - travel_out=0.
    - If room_fb is not a park room → FAULT next cycle.
    - Else, if FIFO is non-empty: pop, load target_room, clear step count, → ROUTE.
  - ROUTE:
    - If room_fb == target_room:
      - arrived=1 next cycle.
      - If park room: travel_out=0, → IDLE.
      - Else: travel_out=move bit, expected ← succ, → PARK.
    - Else: travel_out=move bit, expected ← succ(room_fb), step count+1.
  - PARK:
    - If room_fb is a park room: travel_out=0, → IDLE.
    - Else: travel_out=move bit, expected ← succ.
  - FAULT:
    - travel_out=0, fault=1, cmd_ready=0, busy=1.
    - Exit only by reset; FIFO contents are held but not served.
- Step check:
  - In every ROUTE/PARK cycle following a move, room_fb must equal expected; mismatch → FAULT.
  - In ROUTE, step count reaching MAX_STEPS without arrival → FAULT.
- Latency:
  - Command pushed into an empty FIFO while IDLE → popped 1 cycle later (ROUTE on the 2nd edge).
  - Distance d along the ring → arrived pulses d+1 cycles after ROUTE entry.
- Zero distance: target equals current park room → ROUTE for one cycle, arrived pulse, back to IDLE; no rover motion.
- Reset mid-route: abandons the command immediately, clears the FIFO, travel_out=0 from the reset cycle on.

Test Plan:
- Reset with rover in room 0, FIFO empty → busy=0, fault=0, cmd_ready=1, travel_out=0, fifo_level=0.
- Push target 4 from room 0 → travel_out 1,1,1,1 over 4 cycles; room_fb 1,2,3,4; arrived pulses once; returns to IDLE with travel_out=0, room held at 4.
- From room 4, push target 5 → bits 1 (→6), 0 (→5); arrived pulse; PARK bit 1 (→7); IDLE in room 7.
- Push 4 commands (2, 0, 7, 7) back-to-back while busy → fifo_level reaches 4 and cmd_ready drops; served in order; the second 7 is zero-distance with an arrived pulse and no motion.
- Force room_fb to 5 when 3 is expected during a route → fault=1 next cycle, travel_out=0, cmd_ready=0; stays until reset=0.
- Assert reset=0 mid-route at room 2 (target 7) with 2 queued → next cycle IDLE, fifo_level=0, busy=0, no arrived pulse.

Source files
------------

// File: rtl/figo_route_sequencer.sv
// figo_route_sequencer: steers the Figo rover along its 8-room Hamiltonian
// ring (0-1-2-3-4-6-5-7-0) to queued destination rooms, checking every
// step against the expected room and parking it in a self-looping room.
//
// state | meaning
// IDLE  | rover parked, waiting for a queued command
// ROUTE | stepping toward target_room
// PARK  | target reached in a non-park room, stepping on to a park room
// FAULT | step mismatch, step backstop or unparked idle; held until reset
module figo_route_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3,
  parameter int MAX_STEPS  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_room,
  output logic             cmd_ready,
  input  logic [2:0]       room_fb,
  output logic             travel_out,
  output logic             busy,
  output logic             arrived,
  output logic             fault,
  output logic [2:0]       target_room,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUTE = 2'd1;
  localparam logic [1:0] PARK  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [2:0]       tgt_d, exp_q, exp_d;
  logic             chk_q, chk_d, arr_d, travel, pop, push, full, empty;
  logic [STEP_W-1:0] step_q, step_d;

  function automatic logic [2:0] succ(input logic [2:0] r);
    case (r)
      3'd0: succ = 3'd1;
      3'd1: succ = 3'd2;
      3'd2: succ = 3'd3;
      3'd3: succ = 3'd4;
      3'd4: succ = 3'd6;
      3'd6: succ = 3'd5;
      3'd5: succ = 3'd7;
      default: succ = 3'd0;
    endcase
  endfunction

  function automatic logic is_park(input logic [2:0] r);
    is_park = (r == 3'd0) || (r == 3'd2) || (r == 3'd4) || (r == 3'd7);
  endfunction

  // room 6 is the only room where the rover advances on a 0 input
  function automatic logic move_bit(input logic [2:0] r);
    move_bit = (r != 3'd6);
  endfunction

  assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty      = (fifo_level == '0);
  assign fault      = (state_q == FAULT);
  assign busy       = (state_q != IDLE);
  assign cmd_ready  = !full && !fault;
  assign push       = cmd_valid && cmd_ready;
  assign travel_out = reset && travel;

  // next-state, Mealy travel bit and step checking
  always_comb begin
    state_d = state_q;
    travel  = 1'b0;
    pop     = 1'b0;
    tgt_d   = target_room;
    exp_d   = exp_q;
    chk_d   = chk_q;
    step_d  = step_q;
    arr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        chk_d = 1'b0;
        if (!is_park(room_fb)) begin
          state_d = FAULT;
        end else if (!empty) begin
          pop     = 1'b1;
          tgt_d   = mem[rd_ptr];
          step_d  = '0;
          state_d = ROUTE;
        end
      end
      ROUTE: begin
        if (chk_q && (room_fb != exp_q)) begin
          state_d = FAULT;
        end else if (room_fb == target_room) begin
          arr_d = 1'b1;
          if (is_park(room_fb)) begin
            chk_d   = 1'b0;
            state_d = IDLE;
          end else begin
            travel  = move_bit(room_fb);
            exp_d   = succ(room_fb);
            chk_d   = 1'b1;
            state_d = PARK;
          end
        end else if (step_q >= STEP_W'(MAX_STEPS)) begin
          state_d = FAULT;
        end else begin
          travel = move_bit(room_fb);
          exp_d  = succ(room_fb);
          chk_d  = 1'b1;
          step_d = step_q + STEP_W'(1);
        end
      end
      PARK: begin
        if (chk_q && (room_fb != exp_q)) begin
          state_d = FAULT;
        end else if (is_park(room_fb)) begin
          chk_d   = 1'b0;
          state_d = IDLE;
        end else begin
          travel = move_bit(room_fb);
          exp_d  = succ(room_fb);
          chk_d  = 1'b1;
        end
      end
      default: state_d = FAULT;
    endcase
  end

  // FSM, step tracking and FIFO pointer registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      target_room <= '0;
      exp_q       <= '0;
      chk_q       <= 1'b0;
      step_q      <= '0;
      arrived     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
    end else begin
      state_q     <= state_d;
      target_room <= tgt_d;
      exp_q       <= exp_d;
      chk_q       <= chk_d;
      step_q      <= step_d;
      arrived     <= arr_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // command storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_room;
  end

endmodule

// File: tb/tb_figo_route_sequencer.sv
// Bench for figo_route_sequencer: a rover room model closes the loop,
// arrivals are checked against a queue of expected (target, room) pairs.
module tb_figo_route_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_room = 3'd0;
  logic       cmd_ready, travel_out, busy, arrived, fault;
  logic [2:0] room_fb, target_room;
  logic [2:0] fifo_level;

  logic [2:0] rover = 3'd0;
  logic       rover_load = 1'b0;
  logic [2:0] rover_load_val = 3'd0;
  logic       ovr_en = 1'b0;
  logic [2:0] ovr_val = 3'd0;

  int total = 0;
  int bad = 0;

  typedef struct {
    int tgt;
    int room;
  } exp_t;
  exp_t sb[$];

  figo_route_sequencer #(.FIFO_DEPTH(4), .LVL_W(3), .MAX_STEPS(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_room(cmd_room),
    .cmd_ready(cmd_ready), .room_fb(room_fb), .travel_out(travel_out),
    .busy(busy), .arrived(arrived), .fault(fault),
    .target_room(target_room), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ring_next(input logic [2:0] r);
    case (r)
      3'd0: ring_next = 3'd1;
      3'd1: ring_next = 3'd2;
      3'd2: ring_next = 3'd3;
      3'd3: ring_next = 3'd4;
      3'd4: ring_next = 3'd6;
      3'd6: ring_next = 3'd5;
      3'd5: ring_next = 3'd7;
      default: ring_next = 3'd0;
    endcase
  endfunction

  // rover: room 6 advances on 0, every other room advances on 1 and holds on 0
  function automatic logic [2:0] rover_step(input logic [2:0] r, input logic b);
    if (r == 3'd6) rover_step = b ? r : 3'd5;
    else           rover_step = b ? ring_next(r) : r;
  endfunction

  always @(posedge clk) begin
    if (rover_load) rover <= rover_load_val;
    else            rover <= rover_step(rover, travel_out);
  end

  assign room_fb = ovr_en ? ovr_val : rover;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every arrived pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset && arrived) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_arrived: got target %0d want no pulse", target_room);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("arr_target", target_room, e.tgt);
        chk("arr_room", room_fb, e.room);
      end
    end
  end

  task automatic send(input logic [2:0] r);
    cmd_valid = 1'b1;
    cmd_room  = r;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_bits(input string nm, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", nm, i), travel_out, b[i]);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || fifo_level != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(busy || fifo_level != 0), 0);
  endtask

  initial begin
    // reset with rover in room 0
    repeat (3) @(negedge clk);
    chk("rst_travel", travel_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_arrived", arrived, 0);
    chk("rst_target", target_room, 0);
    reset = 1'b1;
    @(negedge clk);

    // room 0 -> 4: four 1-bits, then parked
    sb.push_back('{4, 4});
    send(3'd4);
    chk("t2_level", fifo_level, 1);
    expect_bits("t2_bits", 8'b0000_1111, 5);
    chk("t2_arr_early", arrived, 0);
    chk("t2_target", target_room, 4);
    @(negedge clk);
    chk("t2_arrived", arrived, 1);
    chk("t2_busy", busy, 0);
    chk("t2_travel_idle", travel_out, 0);
    @(negedge clk);
    chk("t2_room_held", room_fb, 4);

    // room 4 -> 5: bits 1,0 then arrival, park step into 7
    sb.push_back('{5, 7});
    send(3'd5);
    expect_bits("t3_bits", 8'b0000_0101, 4);
    @(negedge clk);
    chk("t3_busy", busy, 0);
    chk("t3_room", room_fb, 7);

    // room 7 -> 4 while four more commands queue up behind it
    sb.push_back('{4, 4});
    sb.push_back('{2, 2});
    sb.push_back('{0, 0});
    sb.push_back('{7, 7});
    sb.push_back('{7, 7});
    send(3'd4);
    @(negedge clk);
    send(3'd2);
    send(3'd0);
    send(3'd7);
    send(3'd7);
    chk("t4_level_full", fifo_level, 4);
    chk("t4_ready_full", cmd_ready, 0);
    chk("t4_busy", busy, 1);
    wait_idle("t4_timeout");
    @(negedge clk);
    chk("t4_room_end", room_fb, 7);
    chk("t4_sb_empty", sb.size(), 0);

    // room 7 -> 3 with room 5 reported where 3 is expected
    send(3'd3);
    repeat (5) @(negedge clk);
    chk("t5_pre_room", room_fb, 3);
    ovr_en  = 1'b1;
    ovr_val = 3'd5;
    #1;
    chk("t5_travel_mismatch", travel_out, 0);
    @(negedge clk);
    chk("t5_fault", fault, 1);
    chk("t5_travel", travel_out, 0);
    chk("t5_ready", cmd_ready, 0);
    chk("t5_busy", busy, 1);
    cmd_valid = 1'b1;
    cmd_room  = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_no_push", fifo_level, 0);
    repeat (3) @(negedge clk);
    chk("t5_sticky", fault, 1);
    reset          = 1'b0;
    ovr_en         = 1'b0;
    rover_load     = 1'b1;
    rover_load_val = 3'd0;
    @(negedge clk);
    rover_load = 1'b0;
    chk("t5_rst_fault", fault, 0);
    chk("t5_rst_travel", travel_out, 0);
    reset = 1'b1;
    @(negedge clk);

    // reset mid-route at room 2 toward 7 with two queued commands
    send(3'd7);
    @(negedge clk);
    send(3'd4);
    send(3'd0);
    chk("t6_room", room_fb, 2);
    chk("t6_level", fifo_level, 2);
    chk("t6_travel_pre", travel_out, 1);
    reset = 1'b0;
    #1;
    chk("t6_travel_rst", travel_out, 0);
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_level_clr", fifo_level, 0);
    chk("t6_arrived", arrived, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle", busy, 0);
    chk("t6_room_held", room_fb, 2);
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
